// File: rtl/fetch_ctrl.sv
// Stage1 fetch sequencer: arbitrates redirects, hazard stalls and icache misses for the PC.
// Define FETCH_PERF_EN to add saturating fetch/stall performance counters.
module fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2
`ifdef FETCH_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_hazard_stall,
  input  logic        i_ic_req_ready,
  input  logic        i_ic_resp_valid,
  output logic        o_ic_req_valid,
  output logic        o_pc_stall,
  output logic        o_pc_sel,
  output logic [31:0] o_pc_target,
  output logic        o_inst_kill,
  output logic        o_s2_stall
`ifdef FETCH_PERF_EN
  , output logic [CNT_W-1:0] o_perf_fetch_cnt
  , output logic [CNT_W-1:0] o_perf_stall_cnt
`endif
);

  localparam int unsigned BootW = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {StBoot, StRun, StMiss} state_e;

  state_e            r_state;
  logic [BootW-1:0]  r_boot_cnt;
  logic              r_pend;
  logic [31:0]       r_pend_tgt;
  logic              w_br_ok;

  // A branch only counts when stage2 is not frozen.
  assign w_br_ok = i_br_taken && !i_hazard_stall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StBoot;
      r_boot_cnt <= '0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
    end else begin
      unique case (r_state)
        StBoot: begin
          r_boot_cnt <= r_boot_cnt + BootW'(1);
          if (r_boot_cnt == BootW'(BOOT_CYCLES - 1)) r_state <= StRun;
        end
        StRun: begin
          if (!i_hazard_stall && !i_br_taken && i_ic_req_ready && !i_ic_resp_valid) begin
            r_state <= StMiss;
          end
        end
        StMiss: begin
          // Same-cycle branch is captured before the response retires it.
          if (w_br_ok) r_pend_tgt <= i_br_target;
          if (i_ic_resp_valid) begin
            r_pend  <= 1'b0;
            r_state <= StRun;
          end else if (w_br_ok) begin
            r_pend <= 1'b1;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  always_comb begin
    o_pc_stall     = 1'b1;
    o_pc_sel       = 1'b0;
    o_pc_target    = r_pend_tgt;
    o_ic_req_valid = 1'b0;
    o_inst_kill    = 1'b1;
    o_s2_stall     = 1'b0;
    unique case (r_state)
      StBoot: o_pc_target = '0;
      StRun: begin
        if (i_hazard_stall) begin
          o_s2_stall = 1'b1;
        end else if (i_br_taken) begin
          o_pc_stall  = 1'b0;
          o_pc_sel    = 1'b1;
          o_pc_target = i_br_target;
        end else begin
          o_ic_req_valid = 1'b1;
          if (i_ic_req_ready && i_ic_resp_valid) begin
            o_pc_stall  = 1'b0;
            o_inst_kill = 1'b0;
          end
        end
      end
      StMiss: begin
        o_s2_stall = i_hazard_stall;
        if (i_ic_resp_valid) begin
          o_pc_stall = 1'b0;
          if (w_br_ok) begin
            o_pc_sel    = 1'b1;
            o_pc_target = i_br_target;
          end else if (r_pend) begin
            o_pc_sel = 1'b1;
          end else begin
            o_inst_kill = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] r_perf_fetch_cnt;
  logic [CNT_W-1:0] r_perf_stall_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_perf_fetch_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (!o_pc_stall && !o_inst_kill && (r_perf_fetch_cnt != '1)) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + CNT_W'(1);
      end
      if ((r_state != StBoot) && o_pc_stall && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch_cnt;
  assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
